// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, CON bit indices and TX/RX state enums shared by uart_mmio and uart_rx_core
package uart_pkg;
  localparam logic [31:0] OFF_TXD = 32'd0;
  localparam logic [31:0] OFF_RXD = 32'd4;
  localparam logic [31:0] OFF_CON = 32'd8;
  localparam int CON_RX_IE = 0;
  localparam int CON_TX_IE = 1;
  localparam int CON_RX_VALID = 2;
  localparam int CON_TX_BUSY = 3;
  localparam int CON_TX_DONE = 4;
  localparam int CON_OVERRUN = 5;
  localparam int CON_FRAME_ERR = 6;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_mmio_if.sv
// uart_mmio_if: CPU load/store bus (address, writedata, write_enable, read_enable in; readdata out) with master/slave modports
interface uart_mmio_if;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic write_enable;
  logic read_enable;
  modport master(output address, writedata, write_enable, read_enable, input readdata);
  modport slave(input address, writedata, write_enable, read_enable, output readdata);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver (clk, active-low sync reset, uart_rx in; data/valid/frame_err pulse out on the stop-bit sample cycle)
module uart_rx_core import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 5208
) (
  input logic clk,
  input logic reset,
  input logic uart_rx,
  output logic [7:0] data,
  output logic valid,
  output logic frame_err
);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  rx_state_t state;
  logic [15:0] cnt;
  logic [2:0] idx;
  logic s1, s2, prev, tick;
  assign tick = cnt == FULL;
  assign valid = state == RX_STOP && tick && s2;
  assign frame_err = state == RX_STOP && tick && !s2;
  always_ff @(posedge clk)
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      prev <= 1'b1;
      state <= RX_IDLE;
      cnt <= '0;
      idx <= '0;
      data <= '0;
    end else begin
      s1 <= uart_rx;
      s2 <= s1;
      prev <= s2;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (prev && !s2) state <= RX_START;
        end
        RX_START: if (cnt == HALF) begin
          cnt <= '0;
          state <= s2 ? RX_IDLE : RX_DATA;
        end else cnt <= cnt + 16'd1;
        RX_DATA: if (tick) begin
          cnt <= '0;
          data <= {s2, data[7:1]};
          idx <= idx + 3'd1;
          if (idx == 3'd7) state <= RX_STOP;
        end else cnt <= cnt + 16'd1;
        RX_STOP: if (tick) begin
          cnt <= '0;
          state <= RX_IDLE;
        end else cnt <= cnt + 16'd1;
      endcase
    end
endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART (clk, active-low sync reset, bus via uart_mmio_if.slave, uart_rx/uart_tx serial, irq); UART_RX_FIFO_EN selects a 4-entry RX FIFO
module uart_mmio import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 5208,
  parameter logic [31:0] BASE = 32'h40000018
) (
  input logic clk,
  input logic reset,
  uart_mmio_if.slave bus,
  input logic uart_rx,
  output logic uart_tx,
  output logic irq
);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  tx_state_t tx_state;
  logic [15:0] tx_cnt;
  logic [2:0] tx_idx;
  logic [7:0] tx_shift, rx_byte, head;
  logic rx_ie, tx_ie, tx_done, overrun, frame_err;
  logic rx_push, rx_ferr, rx_valid, ovf_set, tx_busy, tx_tick, wr_txd, wr_con, pop;
  assign wr_txd = bus.write_enable && bus.address == BASE + OFF_TXD;
  assign wr_con = bus.write_enable && bus.address == BASE + OFF_CON;
  assign pop = bus.read_enable && bus.address == BASE + OFF_RXD;
  assign tx_busy = tx_state != TX_IDLE;
  assign tx_tick = tx_cnt == FULL;
  assign bus.readdata = !bus.read_enable ? '0
    : bus.address == BASE + OFF_RXD ? {24'h0, rx_valid ? head : 8'h0}
    : bus.address == BASE + OFF_CON ? {25'h0, frame_err, overrun, tx_done, tx_busy, rx_valid, tx_ie, rx_ie}
    : '0;
  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk),
    .reset(reset),
    .uart_rx(uart_rx),
    .data(rx_byte),
    .valid(rx_push),
    .frame_err(rx_ferr)
  );
`ifdef UART_RX_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] count;
  logic do_push, do_pop;
  assign do_pop = pop && count != 3'd0;
  assign do_push = rx_push && (count != 3'd4 || pop);
  assign ovf_set = rx_push && count == 3'd4 && !pop;
  assign rx_valid = count != 3'd0;
  assign head = mem[rp];
  always_ff @(posedge clk)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wp] <= rx_byte;
      wp <= wp + 2'(do_push);
      rp <= rp + 2'(do_pop);
      count <= count + 3'(do_push) - 3'(do_pop);
    end
`else
  logic [7:0] hold;
  logic do_push;
  assign do_push = rx_push && (!rx_valid || pop);
  assign ovf_set = rx_push && rx_valid && !pop;
  assign head = hold;
  always_ff @(posedge clk)
    if (!reset) begin
      hold <= '0;
      rx_valid <= 1'b0;
    end else begin
      hold <= do_push ? rx_byte : hold;
      rx_valid <= do_push || (rx_valid && !pop);
    end
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_shift <= '0;
      uart_tx <= 1'b1;
    end else begin
      tx_cnt <= tx_state == TX_IDLE || tx_tick ? '0 : tx_cnt + 16'd1;
      case (tx_state)
        TX_IDLE: if (wr_txd) begin
          tx_shift <= bus.writedata[7:0];
          uart_tx <= 1'b0;
          tx_state <= TX_START;
        end
        TX_START: if (tx_tick) begin
          uart_tx <= tx_shift[0];
          tx_shift <= tx_shift >> 1;
          tx_idx <= '0;
          tx_state <= TX_DATA;
        end
        TX_DATA: if (tx_tick) begin
          uart_tx <= tx_idx == 3'd7 ? 1'b1 : tx_shift[0];
          tx_shift <= tx_shift >> 1;
          tx_idx <= tx_idx + 3'd1;
          if (tx_idx == 3'd7) tx_state <= TX_STOP;
        end
        TX_STOP: if (tx_tick) tx_state <= TX_IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (!reset) begin
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
      tx_done <= 1'b0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
      irq <= 1'b0;
    end else begin
      rx_ie <= wr_con ? bus.writedata[CON_RX_IE] : rx_ie;
      tx_ie <= wr_con ? bus.writedata[CON_TX_IE] : tx_ie;
      tx_done <= (tx_state == TX_STOP && tx_tick) || (tx_done && !(wr_con && bus.writedata[CON_TX_DONE]));
      overrun <= ovf_set || (overrun && !(wr_con && bus.writedata[CON_OVERRUN]));
      frame_err <= rx_ferr || (frame_err && !(wr_con && bus.writedata[CON_FRAME_ERR]));
      irq <= (rx_ie && rx_valid) || (tx_ie && tx_done);
    end
endmodule
